// File: rtl/cache_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller_if
// Description : CPU, main-memory and data-array signal bundle of the cache
//               controller; slave = controller side, master = environment.
// Revision    : 1.0
// ============================================================================
interface cache_controller_if #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int ARRAY_ADDR_WIDTH = 8
);
    logic                        cpu_request;
    logic                        cpu_rw;
    logic                        cpu_bw;
    logic [ADDR_WIDTH-1:0]       cpu_address;
    logic [DATA_WIDTH-1:0]       cpu_write_data;
    logic                        cpu_wait;
    logic                        cpu_done;
    logic [DATA_WIDTH-1:0]       cpu_read_data;

    logic                        mem_request;
    logic                        mem_rw;
    logic                        mem_bw;
    logic [ADDR_WIDTH-1:0]       mem_address;
    logic [DATA_WIDTH-1:0]       mem_write_data;
    logic                        mem_ack;
    logic [DATA_WIDTH-1:0]       mem_read_data;

    logic                        cache_enable;
    logic                        cache_rw;
    logic                        cache_bw;
    logic [ARRAY_ADDR_WIDTH-1:0] cache_address;
    logic [DATA_WIDTH-1:0]       cache_write_value;
    logic [DATA_WIDTH-1:0]       cache_read_value;

    modport slave (
        input  cpu_request, cpu_rw, cpu_bw, cpu_address, cpu_write_data,
        input  mem_ack, mem_read_data, cache_read_value,
        output cpu_wait, cpu_done, cpu_read_data,
        output mem_request, mem_rw, mem_bw, mem_address, mem_write_data,
        output cache_enable, cache_rw, cache_bw, cache_address, cache_write_value
    );

    modport master (
        output cpu_request, cpu_rw, cpu_bw, cpu_address, cpu_write_data,
        output mem_ack, mem_read_data, cache_read_value,
        input  cpu_wait, cpu_done, cpu_read_data,
        input  mem_request, mem_rw, mem_bw, mem_address, mem_write_data,
        input  cache_enable, cache_rw, cache_bw, cache_address, cache_write_value
    );
endinterface
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller
// Description : Direct-mapped, write-through, no-write-allocate cache
//               controller with tag/valid store and 4-word line fills.
// Revision    : 1.0
// ============================================================================
module cache_controller #(
    parameter int LINE_NUMBER    = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32
) (
    input wire                 clock,
    input wire                 reset,
    cache_controller_if.slave  bus
);
    localparam int c_INDEX_W  = $clog2(LINE_NUMBER);
    localparam int c_WORD_W   = $clog2(WORDS_PER_LINE);
    localparam int c_OFFSET_W = c_WORD_W + 2;
    localparam int c_ARR_W    = c_INDEX_W + c_OFFSET_W;
    localparam int c_TAG_W    = ADDR_WIDTH - c_ARR_W;
    localparam logic [c_WORD_W-1:0] c_LAST_WORD = c_WORD_W'(WORDS_PER_LINE - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_RESPOND = 3'd1;
    localparam logic [2:0] c_FILL    = 3'd2;
    localparam logic [2:0] c_REREAD  = 3'd3;
    localparam logic [2:0] c_WMEM    = 3'd4;

    logic [2:0]             r_state;
    logic [LINE_NUMBER-1:0] r_valid;
    logic [c_TAG_W-1:0]     r_tag [LINE_NUMBER];
    logic [c_WORD_W-1:0]    r_count;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_bw;
    logic [DATA_WIDTH-1:0]  r_data;

    logic [c_TAG_W-1:0]     w_cpu_tag;
    logic [c_INDEX_W-1:0]   w_cpu_index;
    logic [c_TAG_W-1:0]     w_lat_tag;
    logic [c_INDEX_W-1:0]   w_lat_index;
    logic                   w_hit;
    logic                   w_accept;
    logic                   w_last_fill;

    assign w_cpu_tag   = bus.cpu_address[ADDR_WIDTH-1:c_ARR_W];
    assign w_cpu_index = bus.cpu_address[c_ARR_W-1:c_OFFSET_W];
    assign w_lat_tag   = r_addr[ADDR_WIDTH-1:c_ARR_W];
    assign w_lat_index = r_addr[c_ARR_W-1:c_OFFSET_W];
    assign w_hit       = r_valid[w_cpu_index] && (r_tag[w_cpu_index] == w_cpu_tag);
    assign w_accept    = (r_state == c_IDLE) && bus.cpu_request;
    assign w_last_fill = (r_state == c_FILL) && bus.mem_ack && (r_count == c_LAST_WORD);

    // Valid is only set on the last fill word, so an aborted fill leaves the line invalid.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_valid <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.cpu_request) begin
                        if (!bus.cpu_rw) begin
                            r_state <= c_WMEM;
                        end else if (w_hit) begin
                            r_state <= c_RESPOND;
                        end else begin
                            r_count <= '0;
                            r_state <= c_FILL;
                        end
                    end
                end
                c_RESPOND: r_state <= c_IDLE;
                c_FILL: begin
                    if (bus.mem_ack) begin
                        r_count <= r_count + c_WORD_W'(1);
                        if (r_count == c_LAST_WORD) begin
                            r_valid[w_lat_index] <= 1'b1;
                            r_state              <= c_REREAD;
                        end
                    end
                end
                c_REREAD: r_state <= c_RESPOND;
                c_WMEM:   if (bus.mem_ack) r_state <= c_IDLE;
                default:  r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_addr <= bus.cpu_address;
            r_bw   <= bus.cpu_bw;
            r_data <= bus.cpu_write_data;
        end
        if (w_last_fill) begin
            r_tag[w_lat_index] <= w_lat_tag;
        end
    end

    always_comb begin
        bus.cpu_wait          = (r_state != c_IDLE);
        bus.cpu_done          = 1'b0;
        bus.cpu_read_data     = '0;
        bus.mem_request       = 1'b0;
        bus.mem_rw            = 1'b0;
        bus.mem_bw            = 1'b0;
        bus.mem_address       = '0;
        bus.mem_write_data    = '0;
        bus.cache_enable      = 1'b0;
        bus.cache_rw          = 1'b0;
        bus.cache_bw          = 1'b0;
        bus.cache_address     = '0;
        bus.cache_write_value = '0;
        case (r_state)
            c_IDLE: begin
                // Write misses bypass the array entirely (no-write-allocate).
                if (bus.cpu_request && w_hit) begin
                    bus.cache_enable  = 1'b1;
                    bus.cache_rw      = bus.cpu_rw;
                    bus.cache_bw      = bus.cpu_bw;
                    bus.cache_address = bus.cpu_address[c_ARR_W-1:0];
                    if (!bus.cpu_rw) bus.cache_write_value = bus.cpu_write_data;
                end
            end
            c_RESPOND: begin
                bus.cpu_done      = 1'b1;
                bus.cpu_read_data = bus.cache_read_value;
            end
            c_FILL: begin
                bus.mem_request = 1'b1;
                bus.mem_rw      = 1'b1;
                bus.mem_address = {w_lat_tag, w_lat_index, r_count, 2'b00};
                if (bus.mem_ack) begin
                    bus.cache_enable      = 1'b1;
                    bus.cache_address     = {w_lat_index, r_count, 2'b00};
                    bus.cache_write_value = bus.mem_read_data;
                end
            end
            c_REREAD: begin
                bus.cache_enable  = 1'b1;
                bus.cache_rw      = 1'b1;
                bus.cache_bw      = r_bw;
                bus.cache_address = r_addr[c_ARR_W-1:0];
            end
            c_WMEM: begin
                bus.mem_request    = 1'b1;
                bus.mem_bw         = r_bw;
                bus.mem_address    = r_addr;
                bus.mem_write_data = r_data;
                bus.cpu_done       = bus.mem_ack;
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_controller
// Description : Directed vector table plus randomized traffic for
//               cache_controller, with memory/array environment and a
//               line-level reference model.
// Revision    : 1.0
// ============================================================================
module tb_cache_controller;
    typedef struct packed {
        logic [31:0] addr;
        logic        rw;
        logic        bw;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic        rw;
        logic        bw;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          hit;
        logic [31:0] rdata;
    } vec_t;

    logic clock;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    cache_controller_if bus ();

    cache_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- environment: main memory and data array ----------------
    logic [31:0] env_mem [int unsigned];
    logic [31:0] arr [64];
    xfer_t       mem_q[$];
    xfer_t       arr_q[$];
    int          lat      = 2;
    int          wait_cnt = 0;
    int          n_acks   = 0;
    bit          rand_lat = 1'b0;

    function automatic int unsigned wkey(input logic [31:0] a);
        return int'({2'b00, a[31:2]});
    endfunction

    function automatic logic [31:0] init_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] env_read(input logic [31:0] a);
        return env_mem.exists(wkey(a)) ? env_mem[wkey(a)] : init_word(a);
    endfunction

    initial begin
        logic [31:0] cur;
        int          lane;
        bus.mem_ack       = 1'b0;
        bus.mem_read_data = '0;
        forever begin
            @(negedge clock);
            if (bus.mem_ack) begin
                bus.mem_ack       = 1'b0;
                bus.mem_read_data = '0;
                wait_cnt          = 0;
            end else if (!bus.mem_request) begin
                wait_cnt = 0;
            end else if (wait_cnt >= lat) begin
                bus.mem_ack = 1'b1;
                n_acks++;
                mem_q.push_back('{bus.mem_address, bus.mem_rw, bus.mem_bw, bus.mem_write_data});
                if (bus.mem_rw) begin
                    bus.mem_read_data = env_read(bus.mem_address);
                end else begin
                    cur  = env_read(bus.mem_address);
                    lane = int'(bus.mem_address[1:0]);
                    if (bus.mem_bw) cur[lane*8 +: 8] = bus.mem_write_data[7:0];
                    else            cur = bus.mem_write_data;
                    env_mem[wkey(bus.mem_address)] = cur;
                end
                lat = rand_lat ? int'($urandom_range(0, 3)) : 2;
            end else begin
                wait_cnt++;
            end
        end
    end

    initial begin
        logic [31:0] w;
        int          lane;
        bus.cache_read_value = '0;
        foreach (arr[i]) arr[i] = '0;
        forever begin
            @(negedge clock);
            #2;
            if (bus.cache_enable) begin
                arr_q.push_back('{32'(bus.cache_address), bus.cache_rw, bus.cache_bw, bus.cache_write_value});
                lane = int'(bus.cache_address[1:0]);
                w    = arr[bus.cache_address[7:2]];
                if (bus.cache_rw) begin
                    bus.cache_read_value = bus.cache_bw ? {4{w[lane*8 +: 8]}} : w;
                end else begin
                    if (bus.cache_bw) w[lane*8 +: 8] = bus.cache_write_value[7:0];
                    else              w = bus.cache_write_value;
                    arr[bus.cache_address[7:2]] = w;
                end
            end
        end
    end

    // ---------------- reference model: tags, valid bits, backing store ----------------
    logic [31:0] ref_mem [int unsigned];
    bit          ref_valid [16];
    logic [23:0] ref_tag [16];

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_mem.exists(wkey(a)) ? ref_mem[wkey(a)] : init_word(a);
    endfunction

    function automatic bit ref_hit(input logic [31:0] a);
        return ref_valid[a[7:4]] && (ref_tag[a[7:4]] == a[31:8]);
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic bw);
        logic [31:0] w;
        w = ref_word(a);
        return bw ? {4{w[int'(a[1:0])*8 +: 8]}} : w;
    endfunction

    task automatic ref_apply(input logic rw, input logic bw, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        if (rw) begin
            ref_valid[a[7:4]] = 1'b1;
            ref_tag[a[7:4]]   = a[31:8];
        end else begin
            w = ref_word(a);
            if (bw) w[int'(a[1:0])*8 +: 8] = d[7:0];
            else    w = d;
            ref_mem[wkey(a)] = w;
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        env_mem[wkey(a)] = d;
        ref_mem[wkey(a)] = d;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic xfer_t mask(input xfer_t x);
        xfer_t m;
        m = x;
        if (m.rw)      m.data = '0;
        else if (m.bw) m.data[31:8] = '0;
        return m;
    endfunction

    function automatic logic [159:0] all_outputs();
        return 160'({bus.cpu_wait, bus.cpu_done, bus.cpu_read_data, bus.mem_request, bus.mem_rw,
                     bus.mem_bw, bus.mem_address, bus.mem_write_data, bus.cache_enable, bus.cache_rw,
                     bus.cache_bw, bus.cache_address, bus.cache_write_value});
    endfunction

    task automatic do_txn(input string nm, input logic rw, input logic bw, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit exp_hit, input logic [31:0] exp_data);
        int          cyc;
        bit          done;
        bit          busy_ok;
        logic [31:0] rdata;
        xfer_t       exp_mem[$];
        xfer_t       exp_arr[$];
        mem_q.delete();
        arr_q.delete();
        rdata = '0;
        @(posedge clock); #1;
        bus.cpu_request    = 1'b1;
        bus.cpu_rw         = rw;
        bus.cpu_bw         = bw;
        bus.cpu_address    = addr;
        bus.cpu_write_data = wdata;
        @(negedge clock); #1;
        check({nm, "_accept"}, 160'(bus.cpu_wait), 160'(0));
        @(posedge clock); #1;
        // Scramble the CPU bus so that only latched values can produce correct results.
        bus.cpu_request    = 1'b0;
        bus.cpu_rw         = ~rw;
        bus.cpu_bw         = ~bw;
        bus.cpu_address    = $urandom();
        bus.cpu_write_data = $urandom();
        done    = 1'b0;
        busy_ok = 1'b1;
        cyc     = 0;
        while (!done && cyc < 200) begin
            @(negedge clock); #1;
            cyc++;
            if (bus.cpu_wait !== 1'b1) busy_ok = 1'b0;
            if (bus.cpu_done === 1'b1) begin
                done  = 1'b1;
                rdata = bus.cpu_read_data;
            end
        end
        check({nm, "_done"}, 160'(done), 160'(1));
        check({nm, "_busy"}, 160'(busy_ok), 160'(1));
        if (rw && exp_hit) check({nm, "_latency"}, 160'(cyc), 160'(1));
        if (rw)            check({nm, "_rdata"}, 160'(rdata), 160'(exp_data));

        if (rw && !exp_hit) begin
            for (int k = 0; k < 4; k++) begin
                exp_mem.push_back('{{addr[31:4], 2'(k), 2'b00}, 1'b1, 1'b0, 32'h0});
                exp_arr.push_back('{32'({addr[7:4], 2'(k), 2'b00}), 1'b0, 1'b0,
                                    ref_word({addr[31:4], 2'(k), 2'b00})});
            end
        end
        if (rw)           exp_arr.push_back('{32'(addr[7:0]), 1'b1, bw, 32'h0});
        else if (exp_hit) exp_arr.push_back('{32'(addr[7:0]), 1'b0, bw, wdata});
        if (!rw)          exp_mem.push_back('{addr, 1'b0, bw, wdata});

        check({nm, "_mem_count"}, 160'(mem_q.size()), 160'(exp_mem.size()));
        for (int k = 0; k < exp_mem.size() && k < mem_q.size(); k++)
            check($sformatf("%s_mem%0d", nm, k), 160'(mask(mem_q[k])), 160'(mask(exp_mem[k])));
        check({nm, "_arr_count"}, 160'(arr_q.size()), 160'(exp_arr.size()));
        for (int k = 0; k < exp_arr.size() && k < arr_q.size(); k++)
            check($sformatf("%s_arr%0d", nm, k), 160'(mask(arr_q[k])), 160'(mask(exp_arr[k])));
        ref_apply(rw, bw, addr, wdata);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        vec_t        vecs[$];
        int          base;
        int          cyc;
        logic [31:0] a;
        logic        rw;
        logic        bw;

        reset              = 1'b1;
        bus.cpu_request    = 1'b0;
        bus.cpu_rw         = 1'b0;
        bus.cpu_bw         = 1'b0;
        bus.cpu_address    = '0;
        bus.cpu_write_data = '0;
        foreach (ref_valid[i]) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = '0;
        end
        preload(32'h100, 32'h11);
        preload(32'h104, 32'h22);
        preload(32'h108, 32'h33);
        preload(32'h10C, 32'h44);
        preload(32'h1100, 32'h55);

        repeat (3) @(posedge clock);
        @(negedge clock); #1;
        check("reset_outputs", all_outputs(), 160'(0));
        @(posedge clock); #1;
        reset = 1'b0;

        //             rw    bw    addr          wdata          hit   rdata
        vecs.push_back('{1'b1, 1'b0, 32'h100,  32'h0,        1'b0, 32'h11});
        vecs.push_back('{1'b1, 1'b0, 32'h108,  32'h0,        1'b1, 32'h33});
        vecs.push_back('{1'b1, 1'b1, 32'h108,  32'h0,        1'b1, 32'h3333_3333});
        vecs.push_back('{1'b1, 1'b1, 32'h109,  32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h105,  32'hAB,       1'b1, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h104,  32'h0,        1'b1, 32'h0000_AB22});
        vecs.push_back('{1'b0, 1'b0, 32'h2000, 32'hDEADBEEF, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h2000, 32'h0,        1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b0, 32'h1100, 32'h0,        1'b0, 32'h55});
        vecs.push_back('{1'b1, 1'b0, 32'h100,  32'h0,        1'b0, 32'h11});
        vecs.push_back('{1'b1, 1'b0, 32'h10C,  32'h0,        1'b1, 32'h44});
        vecs.push_back('{1'b0, 1'b0, 32'h10C,  32'h1234_5678, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 32'h10F,  32'h0,        1'b1, 32'h1212_1212});
        foreach (vecs[i])
            do_txn($sformatf("vec%0d", i), vecs[i].rw, vecs[i].bw, vecs[i].addr,
                   vecs[i].wdata, vecs[i].hit, vecs[i].rdata);

        // Reset in the middle of a line fill, right after the second word is acknowledged.
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
        mem_q.delete();
        base = n_acks;
        bus.cpu_request = 1'b1;
        bus.cpu_rw      = 1'b1;
        bus.cpu_bw      = 1'b0;
        bus.cpu_address = 32'h100;
        @(posedge clock); #1;
        bus.cpu_request = 1'b0;
        cyc = 0;
        while (n_acks < base + 2 && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("midfill_acks", 160'(n_acks - base), 160'(2));
        check("midfill_addr0", 160'(mem_q.size() > 0 ? mem_q[0].addr : 32'hFFFF_FFFF), 160'(32'h100));
        check("midfill_addr1", 160'(mem_q.size() > 1 ? mem_q[1].addr : 32'hFFFF_FFFF), 160'(32'h104));
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock); #1;
        check("midfill_reset_outputs", all_outputs(), 160'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        do_txn("refill", 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h11);

        // Randomized traffic over a few tags sharing four indices to force conflicts.
        rand_lat = 1'b1;
        for (int n = 0; n < 120; n++) begin
            rw = 1'($urandom_range(0, 1));
            bw = 1'($urandom_range(0, 1));
            a  = {24'($urandom_range(1, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  bw ? 2'($urandom_range(0, 3)) : 2'b00};
            do_txn($sformatf("rnd%0d", n), rw, bw, a, $urandom(), ref_hit(a), ref_read(a, bw));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
